// File: rtl/ps2_keycode_source_if.sv
// Keycode bus between the PS/2 keyboard front end and the game logic.
// The source side drives the held movement code plus its two status pulses.
interface ps2_keycode_source_if;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  modport master (
    output keycode,
    output key_valid,
    output frame_err
  );

  modport slave (
    input keycode,
    input key_valid,
    input frame_err
  );
endinterface

// File: rtl/ps2_keycode_source.sv
// PS/2 set-2 keyboard front end for the ball/pacman mover.
// Conditions the raw PS/2 pins, deframes 11-bit frames, decodes make/break/extended
// sequences and holds the HID code of the current movement key (00 when released).
module ps2_keycode_source #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_keycode_source_if.master kc
);

  localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW  = $clog2(TIMEOUT);

  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  TO_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    D_BASE,
    D_BRK,
    D_EXT,
    D_EXTBRK
  } dec_state_t;

  logic           clk_s1, clk_s2;
  logic           data_s1, data_s2;
  logic           filt_clk, filt_clk_d;
  logic [FCW-1:0] filt_cnt;
  logic           strobe;

  frame_state_t   f_state, f_state_next;
  logic [3:0]     bit_cnt, bit_cnt_next;
  logic [7:0]     shift_reg, shift_next;
  logic [TW-1:0]  to_cnt, to_cnt_next;
  logic           byte_rdy, byte_rdy_next;
  logic           frame_err;

  dec_state_t     d_state, d_state_next;
  logic [7:0]     keycode_q, keycode_next;
  logic           key_valid_q, key_valid_next;
  logic           is_prefix;
  logic           use_ext;
  logic [8:0]     mapped;

  // Looks up a scancode in the base or extended table; bit 8 flags a movement key.
  function automatic logic [8:0] map_code(input logic ext, input logic [7:0] sc);
    logic [8:0] res;
    res = 9'h000;
    if (!ext) begin
      case (sc)
        8'h1D:   res = {1'b1, 8'h1A};
        8'h1C:   res = {1'b1, 8'h04};
        8'h1B:   res = {1'b1, 8'h16};
        8'h23:   res = {1'b1, 8'h07};
        default: res = 9'h000;
      endcase
    end else begin
      case (sc)
        8'h75:   res = {1'b1, 8'h1A};
        8'h6B:   res = {1'b1, 8'h04};
        8'h72:   res = {1'b1, 8'h16};
        8'h74:   res = {1'b1, 8'h07};
        default: res = 9'h000;
      endcase
    end
    return res;
  endfunction

  // Two-flop synchronizers; both pins idle high, so reset them high.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Glitch filter: the filtered clock follows the pin only after FILTER_LEN differing samples in a row.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end
  end

  assign strobe = filt_clk_d & ~filt_clk;

  // Frame FSM registers, including the abort timer and the one-cycle byte-ready flag.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      f_state   <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      to_cnt    <= '0;
      byte_rdy  <= 1'b0;
    end else begin
      f_state   <= f_state_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
      to_cnt    <= to_cnt_next;
      byte_rdy  <= byte_rdy_next;
    end
  end

  // Frame FSM next state: steps on falling edges only; an expiring timer aborts unless an edge arrives that cycle.
  always_comb begin
    f_state_next  = f_state;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift_reg;
    byte_rdy_next = 1'b0;
    frame_err     = 1'b0;
    to_cnt_next   = to_cnt;

    if (strobe) begin
      case (f_state)
        IDLE: begin
          if (!data_s2) begin
            f_state_next = DATA;
            bit_cnt_next = 4'd0;
          end
        end
        DATA: begin
          shift_next   = {data_s2, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            f_state_next = PARITY;
          end
        end
        PARITY: begin
          if (^{shift_reg, data_s2}) begin
            f_state_next = STOP;
          end else begin
            frame_err    = 1'b1;
            f_state_next = IDLE;
          end
        end
        STOP: begin
          if (data_s2) begin
            byte_rdy_next = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
          f_state_next = IDLE;
        end
        default: f_state_next = IDLE;
      endcase
    end else if ((f_state != IDLE) && (to_cnt == TO_LAST)) begin
      frame_err    = 1'b1;
      f_state_next = IDLE;
    end

    if (strobe || (f_state == IDLE)) begin
      to_cnt_next = '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt_next = to_cnt + TW'(1);
    end
  end

  assign is_prefix = (shift_reg == 8'hE0) || (shift_reg == 8'hF0);
  assign use_ext   = (d_state == D_EXT) || (d_state == D_EXTBRK);
  assign mapped    = map_code(use_ext, shift_reg);

  // Decoder registers and the held keycode output.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      d_state     <= D_BASE;
      keycode_q   <= 8'h00;
      key_valid_q <= 1'b0;
    end else begin
      d_state     <= d_state_next;
      keycode_q   <= keycode_next;
      key_valid_q <= key_valid_next;
    end
  end

  // Decoder next state: prefixes steer the state, code bytes press or release; stray prefixes are ignored.
  always_comb begin
    d_state_next   = d_state;
    keycode_next   = keycode_q;
    key_valid_next = 1'b0;

    if (byte_rdy) begin
      case (d_state)
        D_BASE: begin
          if (shift_reg == 8'hF0) begin
            d_state_next = D_BRK;
          end else if (shift_reg == 8'hE0) begin
            d_state_next = D_EXT;
          end else if (mapped[8]) begin
            keycode_next   = mapped[7:0];
            key_valid_next = 1'b1;
          end
        end
        D_BRK, D_EXTBRK: begin
          if (!is_prefix) begin
            d_state_next = D_BASE;
            if (mapped[8] && (keycode_q == mapped[7:0])) begin
              keycode_next   = 8'h00;
              key_valid_next = 1'b1;
            end
          end
        end
        D_EXT: begin
          if (shift_reg == 8'hF0) begin
            d_state_next = D_EXTBRK;
          end else if (shift_reg != 8'hE0) begin
            d_state_next = D_BASE;
            if (mapped[8]) begin
              keycode_next   = mapped[7:0];
              key_valid_next = 1'b1;
            end
          end
        end
        default: d_state_next = D_BASE;
      endcase
    end
  end

  assign kc.keycode   = keycode_q;
  assign kc.key_valid = key_valid_q;
  assign kc.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_keycode_source.sv
// Bench for ps2_keycode_source: drives PS/2 frames bit by bit and compares the keycode bus
// against a scancode-level model of the keyboard protocol.
module tb_ps2_keycode_source;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 300;
  localparam int HALF       = 30;
  localparam int GLITCH_AT  = 16;
  localparam int GLITCH_LEN = 3;
  localparam int STROBE_LAT = 2 + FILTER_LEN;

  logic clk = 1'b0;
  logic reset_n;
  logic ps2_clk;
  logic ps2_data;

  ps2_keycode_source_if kc_bus ();

  ps2_keycode_source #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .Clk      (clk),
    .Reset    (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kc       (kc_bus)
  );

  int unsigned cyc = 0;
  logic        rst_q = 1'b1;
  int          checks;
  int          errors;
  int unsigned last_fall_cyc;

  logic [7:0] model_keycode;
  bit         pend_ext;
  bit         pend_brk;
  logic [7:0] exp_q[$];
  int         exp_err;

  logic [7:0] base_scan [4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
  logic [7:0] ext_scan  [4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
  logic [7:0] hid_code  [4] = '{8'h1A, 8'h04, 8'h16, 8'h07};

  // 100 MHz-style bench clock; the period does not matter to the design.
  always #5 clk = ~clk;

  // Cycle count and the reset level the DUT saw at each edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset_n;
  end

  task automatic check_eq(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    model_keycode = 8'h00;
    pend_ext      = 1'b0;
    pend_brk      = 1'b0;
    exp_q.delete();
    exp_err       = 0;
  endtask

  // Protocol-level model: prefixes accumulate until a code byte completes a press or release.
  task automatic model_byte(input logic [7:0] b);
    int hit;
    hit = -1;
    if (b == 8'hF0) begin
      pend_brk = 1'b1;
    end else if (b == 8'hE0) begin
      if (!pend_brk) pend_ext = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if ((pend_ext ? ext_scan[i] : base_scan[i]) == b) hit = i;
      end
      if (hit >= 0) begin
        if (!pend_brk) begin
          model_keycode = hid_code[hit];
          exp_q.push_back(model_keycode);
        end else if (model_keycode == hid_code[hit]) begin
          model_keycode = 8'h00;
          exp_q.push_back(8'h00);
        end
      end
      pend_ext = 1'b0;
      pend_brk = 1'b0;
    end
  endtask

  // Every cycle: reset values while in reset, otherwise each pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst_q) begin
      check_eq("reset_keycode", {24'h0, kc_bus.keycode}, 32'h0);
      check_eq("reset_key_valid", {31'h0, kc_bus.key_valid}, 32'h0);
      check_eq("reset_frame_err", {31'h0, kc_bus.frame_err}, 32'h0);
    end else begin
      if (kc_bus.key_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_key_valid: got pulse with keycode %02h, want no pulse", kc_bus.keycode);
        end else begin
          check_eq("key_valid_keycode", {24'h0, kc_bus.keycode}, {24'h0, exp_q.pop_front()});
        end
      end
      if (kc_bus.frame_err) begin
        checks++;
        if (exp_err == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_frame_err: got pulse at cycle %0d, want none", cyc);
        end else begin
          exp_err--;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half_phase(input logic level, input bit glitch);
    for (int i = 0; i < HALF; i++) begin
      if (glitch && (i == GLITCH_AT)) ps2_clk = ~level;
      if (glitch && (i == GLITCH_AT + GLITCH_LEN)) ps2_clk = level;
      @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    half_phase(1'b1, glitch);
    ps2_clk       = 1'b0;
    last_fall_cyc = cyc;
    half_phase(1'b0, glitch);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_parity, input bit bad_stop, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(~^b ^ bad_parity, glitch);
    send_bit(~bad_stop, glitch);
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input bit glitch);
    model_byte(b);
    send_frame(b, 1'b0, 1'b0, glitch);
  endtask

  task automatic apply_bad_frame(input logic [7:0] b, input bit bad_parity, input bit bad_stop);
    exp_err++;
    send_frame(b, bad_parity, bad_stop, 1'b0);
  endtask

  // Settles, then pins the held keycode to both the model and a hand-computed literal.
  task automatic check_output(input string name, input logic [7:0] literal);
    wait_cycles(4);
    check_eq({name, "_pending_pulses"}, exp_q.size(), 0);
    check_eq({name, "_pending_errors"}, exp_err, 0);
    exp_q.delete();
    exp_err = 0;
    check_eq({name, "_vs_model"}, {24'h0, kc_bus.keycode}, {24'h0, model_keycode});
    check_eq(name, {24'h0, kc_bus.keycode}, {24'h0, literal});
  endtask

  // Bounds the whole run so a stuck DUT still reaches the summary.
  initial begin
    #5_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got no end of test, want completion before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Directed test sequence.
  initial begin
    logic [31:0] err_cyc;
    bit          found;
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    wait_cycles(3);
    reset_n = 1'b1;
    check_output("reset_state", 8'h00);

    $display("[TB] make/break of W, typematic repeat");
    apply_stimulus(8'h1D, 1'b0);
    check_output("w_make", 8'h1A);
    apply_stimulus(8'h1D, 1'b0);
    check_output("w_repeat", 8'h1A);
    apply_stimulus(8'hF0, 1'b0);
    apply_stimulus(8'h1D, 1'b0);
    check_output("w_break", 8'h00);

    $display("[TB] unmapped key and stray prefix inside a break");
    apply_stimulus(8'h15, 1'b0);
    check_output("unmapped_make", 8'h00);
    apply_stimulus(8'h1D, 1'b0);
    apply_stimulus(8'hF0, 1'b0);
    apply_stimulus(8'hE0, 1'b0);
    apply_stimulus(8'h1D, 1'b0);
    check_output("break_ignores_e0", 8'h00);

    $display("[TB] extended arrows and mismatched break");
    apply_stimulus(8'hE0, 1'b0);
    apply_stimulus(8'h6B, 1'b0);
    check_output("left_arrow_make", 8'h04);
    apply_stimulus(8'hE0, 1'b0);
    apply_stimulus(8'hF0, 1'b0);
    apply_stimulus(8'h6B, 1'b0);
    check_output("left_arrow_break", 8'h00);
    apply_stimulus(8'h23, 1'b0);
    check_output("d_make", 8'h07);
    apply_stimulus(8'hF0, 1'b0);
    apply_stimulus(8'h1C, 1'b0);
    check_output("a_break_while_d_held", 8'h07);
    apply_stimulus(8'h1D, 1'b0);
    apply_stimulus(8'hF0, 1'b0);
    apply_stimulus(8'h23, 1'b0);
    check_output("last_key_wins", 8'h1A);

    $display("[TB] parity and stop errors");
    apply_bad_frame(8'h1C, 1'b1, 1'b0);
    check_output("bad_parity", 8'h1A);
    apply_bad_frame(8'h1C, 1'b0, 1'b1);
    check_output("bad_stop", 8'h1A);

    $display("[TB] reset in the middle of a frame");
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    reset_n = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    model_reset();
    wait_cycles(HALF);
    check_output("reset_mid_frame", 8'h00);
    apply_stimulus(8'h23, 1'b0);
    check_output("d_after_reset", 8'h07);
    apply_stimulus(8'hF0, 1'b0);
    apply_stimulus(8'h23, 1'b0);
    check_output("d_break_after_reset", 8'h00);

    $display("[TB] frame abandoned after four data bits");
    exp_err++;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    found   = 1'b0;
    err_cyc = '0;
    for (int i = 0; i < TIMEOUT + 100 && !found; i++) begin
      @(negedge clk);
      if (kc_bus.frame_err) begin
        found   = 1'b1;
        err_cyc = cyc;
      end
    end
    check_eq("timeout_seen", {31'h0, found}, 32'h1);
    check_eq("timeout_latency", err_cyc - last_fall_cyc, STROBE_LAT + TIMEOUT);
    apply_stimulus(8'h1B, 1'b0);
    check_output("s_after_timeout", 8'h16);

    $display("[TB] clock glitches during a frame");
    apply_stimulus(8'h23, 1'b1);
    check_output("d_with_glitches", 8'h07);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
